// File: rtl/key_debounce.sv
// Push-button debouncer: turns a slow divider level into a one-cycle sampling
// strobe, synchronises raw key pins and accepts a level only after a stable run.
module key_debounce #(
    parameter int NUM_KEYS       = 4,
    parameter int STABLE_SAMPLES = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                clk_sys_i,
    input  logic                rst_n_i,
    input  logic                tick_i,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic                tick_o,
    output logic [NUM_KEYS-1:0] key_state_o,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic [NUM_KEYS-1:0] key_release_o
);

    localparam int                  CNT_W    = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [NUM_KEYS-1:0] IDLE_PIN = {NUM_KEYS{ACTIVE_LOW}};

    logic                tick_q_r;
    logic                tick_q2_r;
    logic                stb_s;
    logic                tick_r;
    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] raw_s;
    logic [NUM_KEYS-1:0] state_r;
    logic [NUM_KEYS-1:0] press_r;
    logic [NUM_KEYS-1:0] release_r;
    logic [NUM_KEYS-1:0] state_nxt_s;
    logic [NUM_KEYS-1:0] press_nxt_s;
    logic [NUM_KEYS-1:0] release_nxt_s;
    logic [CNT_W-1:0]    cnt_r     [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_nxt_s [NUM_KEYS];

    // Tick edge detector; history resets high so a level already high at reset release is ignored.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_q_r  <= 1'b1;
            tick_q2_r <= 1'b1;
            tick_r    <= 1'b0;
        end else begin
            tick_q_r  <= tick_i;
            tick_q2_r <= tick_q_r;
            tick_r    <= stb_s;
        end
    end

    assign stb_s = tick_q_r & ~tick_q2_r;

    // Two-stage key synchroniser, parked at the released pin level.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= IDLE_PIN;
            sync2_r <= IDLE_PIN;
        end else begin
            sync1_r <= key_i;
            sync2_r <= sync1_r;
        end
    end

    assign raw_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

    // Per-key run-length acceptance; any sample matching the current state restarts the run.
    always_comb begin
        state_nxt_s   = state_r;
        press_nxt_s   = {NUM_KEYS{1'b0}};
        release_nxt_s = {NUM_KEYS{1'b0}};
        cnt_nxt_s     = cnt_r;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (stb_s) begin
                if (raw_s[k] == state_r[k]) begin
                    cnt_nxt_s[k] = {CNT_W{1'b0}};
                end else if (cnt_r[k] == LAST_CNT) begin
                    state_nxt_s[k]   = raw_s[k];
                    press_nxt_s[k]   = raw_s[k];
                    release_nxt_s[k] = ~raw_s[k];
                    cnt_nxt_s[k]     = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s[k] = cnt_r[k] + CNT_W'(1);
                end
            end else begin
                cnt_nxt_s[k] = cnt_r[k];
            end
        end
    end

    // Debounce state, run counters and registered pulses.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= {NUM_KEYS{1'b0}};
            press_r   <= {NUM_KEYS{1'b0}};
            release_r <= {NUM_KEYS{1'b0}};
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_r[k] <= {CNT_W{1'b0}};
            end
        end else begin
            state_r   <= state_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    assign tick_o        = tick_r;
    assign key_state_o   = state_r;
    assign key_press_o   = press_r;
    assign key_release_o = release_r;

endmodule

// File: tb/tb_key_debounce.sv
// Table-driven bench for key_debounce: each table row is one 16-cycle tick period;
// its expected outputs are queued at the tick rise and checked when tick_o fires.
module tb_key_debounce;

    typedef struct {
        logic [1:0] keys;
        logic [1:0] state;
        logic [1:0] press;
        logic [1:0] rel;
    } vec_t;

    typedef struct {
        logic [1:0] state;
        logic [1:0] press;
        logic [1:0] rel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_i = 1'b0;
    logic [1:0] key_i = 2'b11;
    logic       tick_o;
    logic [1:0] key_state_o;
    logic [1:0] key_press_o;
    logic [1:0] key_release_o;

    int   n_vec = 0;
    int   n_fail = 0;
    int   n_ticks = 0;
    int   cyc_cnt = 0;
    int   last_tick = 0;
    bit   last_valid = 1'b0;
    vec_t tbl[$];
    exp_t sbq[$];

    key_debounce #(
        .NUM_KEYS(2),
        .STABLE_SAMPLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_sys_i(clk),
        .rst_n_i(rst_n),
        .tick_i(tick_i),
        .key_i(key_i),
        .tick_o(tick_o),
        .key_state_o(key_state_o),
        .key_press_o(key_press_o),
        .key_release_o(key_release_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] k, input logic [1:0] s,
                                input logic [1:0] p, input logic [1:0] r);
        vec_t v;
        v.keys = k; v.state = s; v.press = p; v.rel = r;
        return v;
    endfunction

    task automatic add(input int n, input logic [1:0] k, input logic [1:0] s,
                       input logic [1:0] p, input logic [1:0] r);
        for (int i = 0; i < n; i++) tbl.push_back(mk(k, s, p, r));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tick period: keys change at the start of the low phase, expectation queued at the rise.
    task automatic period(input vec_t v);
        exp_t e;
        e.state = v.state; e.press = v.press; e.rel = v.rel;
        key_i  = v.keys;
        tick_i = 1'b0;
        cyc(8);
        tick_i = 1'b1;
        sbq.push_back(e);
        cyc(8);
    endtask

    // Scoreboard consumer: every tick_o pops one expectation; pulses must be absent between ticks.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (tick_o) begin
                n_ticks++;
                if (last_valid) chk("tick_spacing", 8'(cyc_cnt - last_tick), 8'd16);
                last_tick  = cyc_cnt;
                last_valid = 1'b1;
                if (sbq.size() == 0) begin
                    chk("unexpected_tick_o", 8'd1, 8'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("key_state_o", {6'd0, key_state_o}, {6'd0, e.state});
                    chk("key_press_o", {6'd0, key_press_o}, {6'd0, e.press});
                    chk("key_release_o", {6'd0, key_release_o}, {6'd0, e.rel});
                end
            end else begin
                chk("pulse_without_tick", {4'd0, key_press_o, key_release_o}, 8'd0);
            end
        end
    end

    task automatic reset_pulse;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs", {1'b0, tick_o, key_state_o, key_press_o, key_release_o}, 8'd0);
            cyc(1);
        end
        last_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int ticks_before;

        // idle
        add(10, 2'b11, 2'b00, 2'b00, 2'b00);
        // clean press of key0
        add(3, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 2'b01, 2'b01, 2'b00);
        add(1, 2'b10, 2'b01, 2'b00, 2'b00);
        // release key0
        add(3, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b01);
        // bounce: 3 pressed, 1 released, then a full 4-sample run
        add(3, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b00);
        add(3, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 2'b01, 2'b01, 2'b00);
        add(3, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b01);
        // simultaneous press and release of both keys
        add(3, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 2'b00, 2'b11, 2'b11, 2'b00);
        add(3, 2'b11, 2'b11, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b11);

        #1;
        chk("reset_outputs", {1'b0, tick_o, key_state_o, key_press_o, key_release_o}, 8'd0);
        cyc(4);
        rst_n = 1'b1;
        cyc(4);

        for (int i = 0; i < tbl.size(); i++) begin
            period(tbl[i]);
            if (i == 9) begin
                chk("idle_tick_count", 8'(n_ticks), 8'd10);
                chk("idle_sb_empty", 8'(sbq.size()), 8'd0);
            end
        end

        // reset after two pressed strobes, tick_i held high across release
        period(mk(2'b10, 2'b00, 2'b00, 2'b00));
        period(mk(2'b10, 2'b00, 2'b00, 2'b00));
        reset_pulse();
        ticks_before = n_ticks;
        cyc(8);
        chk("no_tick_after_reset", 8'(n_ticks - ticks_before), 8'd0);
        for (int i = 0; i < 3; i++) period(mk(2'b10, 2'b00, 2'b00, 2'b00));
        period(mk(2'b10, 2'b01, 2'b01, 2'b00));
        period(mk(2'b10, 2'b01, 2'b00, 2'b00));

        // reset while pressed: state lost, released key then produces nothing
        reset_pulse();
        for (int i = 0; i < 5; i++) period(mk(2'b11, 2'b00, 2'b00, 2'b00));

        cyc(20);
        chk("sb_drain", 8'(sbq.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
